imem_loader: RTL
================

Name: imem_loader

Overview:
- Upstream fill stage for the 4-bank x 256-bit input memory block.
- Accepts a narrow DATA_W-bit stream on a valid/ready handshake and packs BEATS beats into one 256-bit word.
- Writes each packed word into the memory block through its bank/wr/in write port, for banks 0..3 in order.
- Reports completion so the controller can start issuing reads.

Parameters:
- DATA_W, 32, stream beat width; must divide WORD_W exactly.
- WORD_W, 256, memory word width; must match the memory block.
- NBANK, 4, number of banks to fill per load; bank index width is 2.
- BEATS (localparam), WORD_W/DATA_W = 8, beats per word.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  pulse; begins a full load at bank 0; ignored unless in IDLE.
- s_valid  input  1  stream beat valid.
- s_data  input  DATA_W  stream beat payload.
- s_ready  output  1  beat accepted on a cycle where s_valid & s_ready.
- mem_wr  output  1  write strobe to memory block wr.
- mem_bank  output  2  bank index to memory block bank.
- mem_in  output  WORD_W  packed word to memory block in.
- busy  output  1  high from the cycle after start until done; controller holds off rd while high.
- done  output  1  one-cycle pulse after the last bank write.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, beat_cnt=0, bank=0. Outputs: s_ready=0, mem_wr=0, mem_bank=0, mem_in=0, busy=0, done=0.
- Reset mid-load: any partial word is discarded; no write is issued in the reset cycle.
- All outputs are registered.
- IDLE: s_ready=0, busy=0. start=1 -> FILL next cycle with bank=0, beat_cnt=0.
- FILL: s_ready=1, busy=1.
  - Each accepted beat k (0..BEATS-1) is stored into bits [k*DATA_W +: DATA_W]; the first beat lands in the LSBs.
  - beat_cnt increments; it wraps to 0 on the BEATS-th accepted beat, and state -> WRITE.
  - s_valid=0 stalls without side effects; there is no timeout.
- WRITE: exactly one cycle; s_ready=0, mem_wr=1, mem_bank=bank, mem_in=assembled word.
  - Next state is FILL with bank+1 if bank<NBANK-1.
  - Otherwise next state is DONE.
- DONE: one cycle; done=1, busy=0 in this cycle, s_ready=0. Next state is IDLE with bank=0.
- mem_in keeps its last value when mem_wr=0; the memory block ignores it.
- A start arriving while in FILL/WRITE/DONE is ignored, not queued.
- A start in the same cycle as the DONE->IDLE transition is ignored. Only a start sampled while in IDLE is honoured.
- Timing, start sampled at cycle t, beats streaming every cycle:
  - s_ready=1 from cycle t+1.
  - First mem_wr at t+1+BEATS.
  - Each bank costs BEATS+1 cycles.
  - done at t+1+NBANK*(BEATS+1) = t+37 with defaults.
- The stream is never required to deassert s_valid during WRITE; held beats are accepted on return to FILL.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_W-1:0], the XOR of every beat accepted since the last start.
  - It is cleared to 0 by reset and in the cycle start is accepted.
  - It is valid and stable from the done cycle until the next accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package imem_pkg:
  - WORD_W=256, NBANK=4, bank index width=2.
  - State enum {IDLE, FILL, WRITE, DONE}.
- Sub-module imem_packer: shift/insert register holding beat_cnt and the assembled word. Interface: load, clear, full flag.
- The FSM, bank counter and done/busy logic stay in imem_loader.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 cycles, then release with no start -> all outputs 0, s_ready=0 indefinitely.
- Full load, back-to-back beats: start, then 32 beats s_data=0..31 -> four mem_wr pulses at bank 0,1,2,3, each spaced 9 cycles apart.
  - Bank 0 mem_in = {32'd7,...,32'd0} (beat 0 in LSBs); bank 3 holds 24..31.
  - done exactly once at t+37.
- Stall: s_valid low for 5 cycles after beat 3 of bank 1 -> no write during the stall. That write is delayed by 5 cycles and holds the correct word; later banks are unaffected.
- Start ignored: pulse start in FILL, WRITE and DONE cycles -> no restart, bank sequence unchanged, exactly one done.
- Reset mid-load: reset_n=0 after beat 5 of bank 2, then start again -> load restarts at bank 0, old partial beats never appear in mem_in, no stray mem_wr.
- With IMEM_LOADER_CHECKSUM_EN: beats 0..31 -> checksum=32'h0 at done. Beats all 32'hA5A5A5A5 except one beat of 32'h1 -> checksum=32'hA5A5A5A4.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the input-memory fill path.
//   WORD_W  : width of one memory word (must match the 4-bank memory block)
//   NBANK   : number of banks written per load
//   BANK_W  : width of the bank index
//   state_t : loader FSM states
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int WORD_W = 256;
   localparam int NBANK  = 4;
   localparam int BANK_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/imem_packer.sv
// -----------------------------------------------------------------------------
// imem_packer
// Packs DATA_W-bit beats into one WORD_W-bit word, beat 0 in the LSBs.
// Ports:
//   clock     : system clock
//   reset_n   : synchronous active-low reset (clears beat count and lanes)
//   clear     : restart packing at beat 0 (new load)
//   load      : accept 'data' into the current beat slot
//   data      : beat payload
//   word_fill : assembled word including the beat being loaded this cycle
//   full      : this cycle's load completes the word
// -----------------------------------------------------------------------------
module imem_packer
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int WORD_W = imem_pkg::WORD_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic [WORD_W-1:0] word_fill,
   output logic              full
);

   localparam int BEATS = WORD_W / DATA_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             last_beat;

   assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));
   assign full      = load & ~clear & last_beat;

   always_comb begin
      cnt_next = cnt_reg;
      if (clear) begin
         cnt_next = '0;
      end else if (load) begin
         cnt_next = last_beat ? '0 : cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // One register per beat slot. word_fill bypasses the beat being loaded so
   // the completed word is available in the same cycle as the final beat,
   // which lets the loader register it straight into its output.
   // Stale lanes are never cleared: a word is only consumed after all BEATS
   // slots of the current load have been rewritten.
   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_lane
         logic [DATA_W-1:0] lane_reg;
         logic              hit;

         assign hit = load & (cnt_reg == CNT_W'(gi));

         always_ff @(posedge clock) begin
            if (!reset_n) begin
               lane_reg <= '0;
            end else if (hit) begin
               lane_reg <= data;
            end
         end

         assign word_fill[gi*DATA_W +: DATA_W] = hit ? data : lane_reg;
      end
   endgenerate

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Fill stage for the 4-bank x 256-bit input memory. Packs BEATS stream beats
// per word and writes banks 0..NBANK-1 in order after each start pulse.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add the 'checksum'
// output (XOR of every beat accepted since the last accepted start).
// Ports:
//   clock    : system clock
//   reset_n  : synchronous active-low reset
//   start    : begin a load (honoured only in IDLE)
//   s_valid  : stream beat valid
//   s_data   : stream beat payload
//   s_ready  : loader can take a beat this cycle
//   mem_wr   : memory write strobe
//   mem_bank : memory bank index
//   mem_in   : packed word to memory (holds last value when mem_wr=0)
//   busy     : load in progress (FILL/WRITE)
//   done     : one-cycle pulse after the last bank write
//   checksum : (IMEM_LOADER_CHECKSUM_EN only) XOR of accepted beats
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_loader
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int WORD_W = imem_pkg::WORD_W,
   parameter int NBANK  = imem_pkg::NBANK
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_wr,
   output logic [BANK_W-1:0] mem_bank,
   output logic [WORD_W-1:0] mem_in,
   output logic              busy,
   output logic              done
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   state_t            state_reg, state_next;
   logic [BANK_W-1:0] bank_reg, bank_next;

   logic              s_ready_reg, s_ready_next;
   logic              mem_wr_reg, mem_wr_next;
   logic [BANK_W-1:0] mem_bank_reg, mem_bank_next;
   logic [WORD_W-1:0] mem_in_reg, mem_in_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;

   logic              accept;
   logic              clear;
   logic              full;
   logic [WORD_W-1:0] word_fill;

   // s_ready_reg is high exactly while the FSM sits in FILL.
   assign accept = s_valid & s_ready_reg;

   imem_packer #(
      .DATA_W (DATA_W),
      .WORD_W (WORD_W)
   ) u_packer (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (clear),
      .load      (accept),
      .data      (s_data),
      .word_fill (word_fill),
      .full      (full)
   );

   always_comb begin
      state_next = state_reg;
      bank_next  = bank_reg;
      clear      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = FILL;
               bank_next  = '0;
               clear      = 1'b1;
            end
         end
         FILL: begin
            if (full) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (bank_reg == BANK_W'(NBANK - 1)) begin
               state_next = DONE;
            end else begin
               state_next = FILL;
               bank_next  = bank_reg + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
            bank_next  = '0;
         end
         default: begin
            state_next = IDLE;
            bank_next  = '0;
         end
      endcase

      // Outputs are decoded from the next state and registered, so they line
      // up with the state they describe.
      s_ready_next  = (state_next == FILL);
      mem_wr_next   = (state_next == WRITE);
      busy_next     = (state_next == FILL) || (state_next == WRITE);
      done_next     = (state_next == DONE);
      mem_bank_next = mem_wr_next ? bank_reg : mem_bank_reg;
      mem_in_next   = full ? word_fill : mem_in_reg;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         bank_reg     <= '0;
         s_ready_reg  <= 1'b0;
         mem_wr_reg   <= 1'b0;
         mem_bank_reg <= '0;
         mem_in_reg   <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bank_reg     <= bank_next;
         s_ready_reg  <= s_ready_next;
         mem_wr_reg   <= mem_wr_next;
         mem_bank_reg <= mem_bank_next;
         mem_in_reg   <= mem_in_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   assign s_ready  = s_ready_reg;
   assign mem_wr   = mem_wr_reg;
   assign mem_bank = mem_bank_reg;
   assign mem_in   = mem_in_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_reg;

   // Cleared on the start that opens a load; no beat can be accepted in that
   // cycle, so clear and accumulate never collide.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         checksum_reg <= '0;
      end else if (clear) begin
         checksum_reg <= '0;
      end else if (accept) begin
         checksum_reg <= checksum_reg ^ s_data;
      end
   end

   assign checksum = checksum_reg;
`endif

endmodule
